card_dealer: RTL and testbench

Shared card-dealing resource for the blackjack datapath. It arbitrates the game FSM's `deal_player`/`deal_dealer` requests onto a single 52-card deck. It draws a non-repeating card using an LFSR and a used-card mask, then updates the player and dealer hand totals with soft-ace handling. It returns each card over the `card_ready` four-phase handshake and drives the `player_sum`, `dealer_sum`, `dealer_bust` and `dealer_auto_hit` inputs that the game FSM consumes.

---
 rtl/blackjack_pkg.sv | 35 +++
 rtl/lfsr6.sv | 22 ++
 rtl/card_dealer.sv | 185 ++++++++++++++++++
 tb/tb_card_dealer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared deck constants, card type and dealer states
// for the blackjack datapath.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int BLACKJACK = 21;
  localparam logic [3:0] ACE_RANK = 4'd0;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
  } card_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_UPDATE,
    S_READY
  } deal_state_e;

  function automatic logic [3:0] card_value(
    input logic [3:0] rank
  );
    logic [3:0] v;
    v = 4'd10;
    unique case (1'b1)
      (rank == ACE_RANK): v = 4'd11;
      (rank >= 4'd1 && rank <= 4'd9):
        v = rank + 4'd1;
      (rank >= 4'd10): v = 4'd10;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/lfsr6.sv
// lfsr6: free-running 6-bit Fibonacci LFSR,
// x^6+x^5+1, period 63.
module lfsr6 #(
  parameter logic [5:0] SEED = 6'h2B
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] q
);

  logic [5:0] q_q, q_d;

  always_comb q_d = {q_q[4:0], q_q[5] ^ q_q[4]};

  always_ff @(posedge clk) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/card_dealer.sv
// card_dealer: arbitrates player/dealer card requests onto one deck
// and keeps both blackjack hand totals with soft-ace handling.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [5:0] SEED         = 6'h2B,
  parameter int         DEALER_STAND = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_player,
  input  logic       deal_dealer,
  input  logic       clear_sums,
  output logic       card_ready,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic       card_to_dealer,
  output logic [5:0] player_sum,
  output logic [5:0] dealer_sum,
  output logic       player_bust,
  output logic       dealer_bust,
  output logic       dealer_auto_hit,
  output logic [5:0] cards_left,
  output logic       reshuffled
);

  localparam logic [5:0] DECK  = 6'(DECK_SIZE);
  localparam logic [6:0] BJ    = 7'(BLACKJACK);
  localparam logic [5:0] STAND = 6'(DEALER_STAND);

  deal_state_e          state_q, state_d;
  logic                 grant_dlr_q, grant_dlr_d;
  logic [DECK_SIZE-1:0] used_q, used_d;
  logic [5:0]           left_q, left_d;
  card_t                card_q, card_d;
  logic                 to_dlr_q, to_dlr_d;
  logic [5:0]           psum_q, psum_d;
  logic [5:0]           dsum_q, dsum_d;
  logic [2:0]           pace_q, pace_d;
  logic [2:0]           dace_q, dace_d;
  logic                 ready_q, ready_d;
  logic                 reshuf_q, reshuf_d;

  logic [5:0] lfsr;
  logic [5:0] idx;
  logic       hit;
  logic       req_g;
  logic [6:0] raw;
  logic [2:0] aces;
  logic [5:0] new_sum;

  lfsr6 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign idx   = lfsr - 6'd1;
  assign hit   = (idx < DECK) && !used_q[idx];
  assign req_g = grant_dlr_q ? deal_dealer : deal_player;

  // one soft ace is demoted at most once per card
  always_comb begin
    raw  = {1'b0, grant_dlr_q ? dsum_q : psum_q}
         + {3'b0, card_value(card_q.rank)};
    aces = grant_dlr_q ? dace_q : pace_q;
    if (card_q.rank == ACE_RANK) aces = aces + 3'd1;
    if (raw > BJ && aces != 3'd0) begin
      raw  = raw - 7'd10;
      aces = aces - 3'd1;
    end
    new_sum = (raw > 7'd63) ? 6'd63 : raw[5:0];
  end

  always_comb begin
    state_d     = state_q;
    grant_dlr_d = grant_dlr_q;
    used_d      = used_q;
    left_d      = left_q;
    card_d      = card_q;
    to_dlr_d    = to_dlr_q;
    psum_d      = psum_q;
    dsum_d      = dsum_q;
    pace_d      = pace_q;
    dace_d      = dace_q;
    ready_d     = ready_q;
    reshuf_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (deal_player || deal_dealer) begin
          grant_dlr_d = !deal_player;
          state_d     = S_DRAW;
          if (left_q == 6'd0) begin
            used_d   = '0;
            left_d   = DECK;
            reshuf_d = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (hit) begin
          used_d[idx] = 1'b1;
          left_d      = left_q - 6'd1;
          card_d      = '{rank: idx[5:2],
                          suit: idx[1:0]};
          to_dlr_d    = grant_dlr_q;
          state_d     = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (grant_dlr_q) begin
          dsum_d = new_sum;
          dace_d = aces;
        end else begin
          psum_d = new_sum;
          pace_d = aces;
        end
        ready_d = 1'b1;
        state_d = S_READY;
      end
      S_READY: begin
        if (!req_g) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase

    if (clear_sums) begin
      psum_d  = '0;
      dsum_d  = '0;
      pace_d  = '0;
      dace_d  = '0;
      used_d  = '0;
      left_d  = DECK;
      ready_d = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_dlr_q <= 1'b0;
      used_q      <= '0;
      left_q      <= DECK;
      card_q      <= '0;
      to_dlr_q    <= 1'b0;
      psum_q      <= '0;
      dsum_q      <= '0;
      pace_q      <= '0;
      dace_q      <= '0;
      ready_q     <= 1'b0;
      reshuf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_dlr_q <= grant_dlr_d;
      used_q      <= used_d;
      left_q      <= left_d;
      card_q      <= card_d;
      to_dlr_q    <= to_dlr_d;
      psum_q      <= psum_d;
      dsum_q      <= dsum_d;
      pace_q      <= pace_d;
      dace_q      <= dace_d;
      ready_q     <= ready_d;
      reshuf_q    <= reshuf_d;
    end
  end

  assign card_ready      = ready_q;
  assign card_rank       = card_q.rank;
  assign card_suit       = card_q.suit;
  assign card_to_dealer  = to_dlr_q;
  assign player_sum      = psum_q;
  assign dealer_sum      = dsum_q;
  assign player_bust     = {1'b0, psum_q} > BJ;
  assign dealer_bust     = {1'b0, dsum_q} > BJ;
  assign dealer_auto_hit = dsum_q < STAND;
  assign cards_left      = left_q;
  assign reshuffled      = reshuf_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed vectors and handshake sequences
// for card_dealer.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       deal_player;
  logic       deal_dealer;
  logic       clear_sums;
  logic       card_ready;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic       card_to_dealer;
  logic [5:0] player_sum;
  logic [5:0] dealer_sum;
  logic       player_bust;
  logic       dealer_bust;
  logic       dealer_auto_hit;
  logic [5:0] cards_left;
  logic       reshuffled;

  int tests  = 0;
  int fails  = 0;
  int rs_cnt = 0;
  logic [5:0] m;

  typedef struct {
    bit clr;
    bit dlr;
    int idx;
    int sum;
    bit bust;
    bit hit;
  } vec_t;

  vec_t vt[11];
  bit   seen[64];

  card_dealer #(
    .SEED         (6'h2B),
    .DEALER_STAND (17)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .deal_player     (deal_player),
    .deal_dealer     (deal_dealer),
    .clear_sums      (clear_sums),
    .card_ready      (card_ready),
    .card_rank       (card_rank),
    .card_suit       (card_suit),
    .card_to_dealer  (card_to_dealer),
    .player_sum      (player_sum),
    .dealer_sum      (dealer_sum),
    .player_bust     (player_bust),
    .dealer_bust     (dealer_bust),
    .dealer_auto_hit (dealer_auto_hit),
    .cards_left      (cards_left),
    .reshuffled      (reshuffled)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] nxt(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4]};
  endfunction

  function automatic int valf(input int r);
    if (r == 0) return 11;
    if (r <= 9) return r + 1;
    return 10;
  endfunction

  // reference LFSR position, used to time targeted draws
  always @(posedge clk) m <= rst ? 6'h2B : nxt(m);

  always @(negedge clk)
    if (reshuffled === 1'b1) rs_cnt <= rs_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic set_req(input bit dlr, input bit v);
    if (dlr) deal_dealer = v;
    else     deal_player = v;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (card_ready !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_req(input bit dlr, input string nm);
    set_req(dlr, 1'b0);
    @(negedge clk);
    chk({nm, " ready drop"}, card_ready, 0);
  endtask

  task automatic hand_add(inout int s, inout int a,
                          input int r);
    s += valf(r);
    if (r == 0) a++;
    if (s > 21 && a > 0) begin
      s -= 10;
      a--;
    end
    if (s > 63) s = 63;
  endtask

  task automatic deal_card(input bit dlr, input int idx,
                           input string nm);
    int w;
    int lat;
    w = 0;
    while (nxt(m) != 6'(idx + 1) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " sync"}, 32'(w < 200), 1);
    set_req(dlr, 1'b1);
    wait_ready(lat);
    chk({nm, " latency"}, lat, 3);
    chk({nm, " rank"}, card_rank, idx / 4);
    chk({nm, " suit"}, card_suit, idx % 4);
    chk({nm, " to_dealer"}, card_to_dealer, dlr);
    release_req(dlr, nm);
  endtask

  initial begin
    int lat;
    int cl;
    int ps;
    int pa;
    int k;
    int rs0;

    vt[0]  = '{1, 0,  0, 11, 0, 1};
    vt[1]  = '{0, 0, 32, 20, 0, 1};
    vt[2]  = '{0, 0, 16, 15, 0, 1};
    vt[3]  = '{0, 1, 48, 10, 0, 1};
    vt[4]  = '{0, 1, 44, 20, 0, 0};
    vt[5]  = '{0, 1, 17, 25, 1, 0};
    vt[6]  = '{1, 0,  1, 11, 0, 1};
    vt[7]  = '{0, 0,  2, 12, 0, 1};
    vt[8]  = '{0, 0, 49, 12, 0, 1};
    vt[9]  = '{0, 0, 33, 21, 0, 1};
    vt[10] = '{0, 0, 37, 31, 1, 1};

    rst         = 1'b1;
    deal_player = 1'b0;
    deal_dealer = 1'b0;
    clear_sums  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    chk("rst card_ready", card_ready, 0);
    chk("rst player_sum", player_sum, 0);
    chk("rst dealer_sum", dealer_sum, 0);
    chk("rst cards_left", cards_left, 52);
    chk("rst auto_hit", dealer_auto_hit, 1);
    chk("rst reshuffled", reshuffled, 0);

    set_req(0, 1'b1);
    wait_ready(lat);
    chk("single latency", 32'(lat >= 3 && lat <= 65), 1);
    chk("single sum", player_sum, valf(card_rank));
    chk("single left", cards_left, 51);
    chk("single to_dealer", card_to_dealer, 0);
    @(negedge clk);
    chk("single ready held", card_ready, 1);
    release_req(0, "single");

    deal_player = 1'b1;
    deal_dealer = 1'b1;
    wait_ready(lat);
    chk("both first latency",
        32'(lat >= 3 && lat <= 65), 1);
    chk("both first to_dealer", card_to_dealer, 0);
    release_req(0, "both first");
    wait_ready(lat);
    chk("both second latency",
        32'(lat >= 3 && lat <= 65), 1);
    chk("both second to_dealer", card_to_dealer, 1);
    chk("both dealer_sum", dealer_sum, valf(card_rank));
    chk("both left", cards_left, 49);
    release_req(1, "both second");

    set_req(0, 1'b1);
    @(negedge clk);
    set_req(0, 1'b0);
    wait_ready(lat);
    chk("early ready", card_ready, 1);
    @(negedge clk);
    chk("early one cycle", card_ready, 0);
    chk("early left", cards_left, 48);

    cl = 0;
    foreach (vt[i]) begin
      if (vt[i].clr) begin
        clear_sums = 1'b1;
        @(negedge clk);
        clear_sums = 1'b0;
        cl = 52;
      end
      deal_card(vt[i].dlr, vt[i].idx, $sformatf("vec%0d", i));
      cl--;
      chk($sformatf("vec%0d sum", i),
          vt[i].dlr ? dealer_sum : player_sum, vt[i].sum);
      chk($sformatf("vec%0d bust", i),
          vt[i].dlr ? dealer_bust : player_bust, vt[i].bust);
      chk($sformatf("vec%0d auto_hit", i),
          dealer_auto_hit, vt[i].hit);
      chk($sformatf("vec%0d left", i), cards_left, cl);
    end

    set_req(0, 1'b1);
    @(negedge clk);
    clear_sums = 1'b1;
    set_req(0, 1'b0);
    @(negedge clk);
    clear_sums = 1'b0;
    chk("clr ready", card_ready, 0);
    chk("clr player_sum", player_sum, 0);
    chk("clr dealer_sum", dealer_sum, 0);
    chk("clr left", cards_left, 52);
    repeat (3) @(negedge clk);
    chk("clr stays idle", card_ready, 0);

    ps  = 0;
    pa  = 0;
    rs0 = rs_cnt;
    for (int i = 0; i < 52; i++) begin
      set_req(0, 1'b1);
      wait_ready(lat);
      chk("deck latency", 32'(lat >= 3 && lat <= 65), 1);
      k = int'(card_rank) * 4 + int'(card_suit);
      chk("deck unique",
          32'(card_rank < 13 && !seen[k]), 1);
      seen[k] = 1'b1;
      hand_add(ps, pa, int'(card_rank));
      chk("deck sum", player_sum, ps);
      release_req(0, "deck");
    end
    chk("deck empty", cards_left, 0);
    chk("deck bust", player_bust, 32'(ps > 21));
    chk("deck no reshuffle", rs_cnt - rs0, 0);

    rs0 = rs_cnt;
    set_req(0, 1'b1);
    wait_ready(lat);
    chk("refill latency", 32'(lat >= 3 && lat <= 65), 1);
    chk("refill pulses", rs_cnt - rs0, 1);
    chk("refill left", cards_left, 51);
    release_req(0, "refill");

    set_req(1, 1'b1);
    wait_ready(lat);
    chk("rst pre ready", card_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2 card_ready", card_ready, 0);
    chk("rst2 player_sum", player_sum, 0);
    chk("rst2 dealer_sum", dealer_sum, 0);
    chk("rst2 left", cards_left, 52);
    chk("rst2 auto_hit", dealer_auto_hit, 1);
    chk("rst2 rank", card_rank, 0);
    chk("rst2 suit", card_suit, 0);
    chk("rst2 to_dealer", card_to_dealer, 0);
    chk("rst2 dealer_bust", dealer_bust, 0);
    rst = 1'b0;
    set_req(1, 1'b0);
    @(negedge clk);
    chk("post rst idle", card_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
